// File: rtl/ctrl_pipe_regs_if.sv
// Control bundle between the decoders/hazard unit and the ID/EX, EX/MEM, MEM/WB
// control registers of the pipelined RV32I core.
interface ctrl_pipe_regs_if #(
  parameter int RD_W      = 5,
  parameter int ALUCTRL_W = 3
);
  // Decode-stage controls and Execute-stage inputs
  logic                 FlushE;
  logic                 RegWriteD;
  logic [1:0]           ResultSrcD;
  logic                 MemWriteD;
  logic                 JumpD;
  logic                 BranchD;
  logic                 ALUSrcD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic [RD_W-1:0]      RdD;
  logic                 ZeroE;

  // Execute-stage copies and redirect
  logic                 RegWriteE;
  logic [1:0]           ResultSrcE;
  logic                 MemWriteE;
  logic                 JumpE;
  logic                 BranchE;
  logic                 ALUSrcE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic [RD_W-1:0]      RdE;
  logic                 ValidE;
  logic                 PCSrcE;

  // Memory- and Writeback-stage copies
  logic                 RegWriteM;
  logic [1:0]           ResultSrcM;
  logic                 MemWriteM;
  logic [RD_W-1:0]      RdM;
  logic                 ValidM;
  logic                 RegWriteW;
  logic [1:0]           ResultSrcW;
  logic [RD_W-1:0]      RdW;
  logic                 ValidW;

  modport master (
    output FlushE, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ALUControlD, RdD, ZeroE,
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
           RdE, ValidE, PCSrcE, RegWriteM, ResultSrcM, MemWriteM, RdM, ValidM,
           RegWriteW, ResultSrcW, RdW, ValidW
  );

  modport slave (
    input  FlushE, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ALUControlD, RdD, ZeroE,
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
           RdE, ValidE, PCSrcE, RegWriteM, ResultSrcM, MemWriteM, RdM, ValidM,
           RegWriteW, ResultSrcW, RdW, ValidW
  );
endinterface

// File: rtl/ctrl_pipe_regs.sv
// Control pipeline registers (E, M, W banks) and Execute-stage redirect PCSrcE.
// Optional flush counter output BubbleCnt is enabled by defining CTRL_BUBBLE_CNT_EN.
module ctrl_pipe_regs #(
  parameter int RD_W      = 5,
  parameter int ALUCTRL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  ctrl_pipe_regs_if.slave  bus
`ifdef CTRL_BUBBLE_CNT_EN
  ,
  output logic [31:0]      BubbleCnt
`endif
);

  typedef struct packed {
    logic                 reg_write;
    logic [1:0]           result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [RD_W-1:0]      rd;
    logic                 valid;
  } e_bank_t;

  e_bank_t e_next;

  // A flushed slot becomes an all-zero bubble, so Rd never aliases a real register.
  always_comb begin
    // NOTE: default first so every path assigns e_next and no latch is inferred.
    e_next = '0;
    if (!bus.FlushE) begin
      e_next.reg_write   = bus.RegWriteD;
      e_next.result_src  = bus.ResultSrcD;
      e_next.mem_write   = bus.MemWriteD;
      e_next.jump        = bus.JumpD;
      e_next.branch      = bus.BranchD;
      e_next.alu_src     = bus.ALUSrcD;
      e_next.alu_control = bus.ALUControlD;
      e_next.rd          = bus.RdD;
      e_next.valid       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every bank samples the previous stage's old value.
    if (reset) begin
      bus.RegWriteE   <= 1'b0;
      bus.ResultSrcE  <= '0;
      bus.MemWriteE   <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUSrcE     <= 1'b0;
      bus.ALUControlE <= '0;
      bus.RdE         <= '0;
      bus.ValidE      <= 1'b0;
      bus.RegWriteM   <= 1'b0;
      bus.ResultSrcM  <= '0;
      bus.MemWriteM   <= 1'b0;
      bus.RdM         <= '0;
      bus.ValidM      <= 1'b0;
      bus.RegWriteW   <= 1'b0;
      bus.ResultSrcW  <= '0;
      bus.RdW         <= '0;
      bus.ValidW      <= 1'b0;
    end else begin
      bus.RegWriteE   <= e_next.reg_write;
      bus.ResultSrcE  <= e_next.result_src;
      bus.MemWriteE   <= e_next.mem_write;
      bus.JumpE       <= e_next.jump;
      bus.BranchE     <= e_next.branch;
      bus.ALUSrcE     <= e_next.alu_src;
      bus.ALUControlE <= e_next.alu_control;
      bus.RdE         <= e_next.rd;
      bus.ValidE      <= e_next.valid;
      bus.RegWriteM   <= bus.RegWriteE;
      bus.ResultSrcM  <= bus.ResultSrcE;
      bus.MemWriteM   <= bus.MemWriteE;
      bus.RdM         <= bus.RdE;
      bus.ValidM      <= bus.ValidE;
      bus.RegWriteW   <= bus.RegWriteM;
      bus.ResultSrcW  <= bus.ResultSrcM;
      bus.RdW         <= bus.RdM;
      bus.ValidW      <= bus.ValidM;
    end
  end

  // Bubbles and reset leave BranchE/JumpE at 0, so no redirect can come from them.
  assign bus.PCSrcE = (bus.BranchE & bus.ZeroE) | bus.JumpE;

`ifdef CTRL_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)           BubbleCnt <= '0;
    else if (bus.FlushE) BubbleCnt <= BubbleCnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed, table-driven bench for ctrl_pipe_regs with hand-computed expectations.
`timescale 1ns/1ps
module tb_ctrl_pipe_regs;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_pipe_regs_if #(.RD_W(5), .ALUCTRL_W(3)) bus ();

`ifdef CTRL_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
  ctrl_pipe_regs #(.RD_W(5), .ALUCTRL_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus), .BubbleCnt(bubble_cnt));
`else
  ctrl_pipe_regs #(.RD_W(5), .ALUCTRL_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;

  // D bundle: {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, ALUControl[2:0], Rd[4:0]}
  typedef struct {
    logic        flush;
    logic        zero;
    logic [14:0] d;
    logic [15:0] e;   // {D fields, ValidE}
    logic [9:0]  m;   // {RegWrite, ResultSrc, MemWrite, Rd, ValidM}
    logic [8:0]  w;   // {RegWrite, ResultSrc, Rd, ValidW}
    logic        pc;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [14:0] dv(logic rw, logic [1:0] rs, logic mw, logic j,
                                     logic b, logic as, logic [2:0] ac, logic [4:0] rd);
    return {rw, rs, mw, j, b, as, ac, rd};
  endfunction

  function automatic logic [15:0] ev(logic v, logic rw, logic [1:0] rs, logic mw, logic j,
                                     logic b, logic as, logic [2:0] ac, logic [4:0] rd);
    return {rw, rs, mw, j, b, as, ac, rd, v};
  endfunction

  function automatic logic [9:0] mv(logic v, logic rw, logic [1:0] rs, logic mw, logic [4:0] rd);
    return {rw, rs, mw, rd, v};
  endfunction

  function automatic logic [8:0] wv(logic v, logic rw, logic [1:0] rs, logic [4:0] rd);
    return {rw, rs, rd, v};
  endfunction

  function automatic logic [15:0] act_e();
    return {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE, bus.BranchE,
            bus.ALUSrcE, bus.ALUControlE, bus.RdE, bus.ValidE};
  endfunction

  function automatic logic [9:0] act_m();
    return {bus.RegWriteM, bus.ResultSrcM, bus.MemWriteM, bus.RdM, bus.ValidM};
  endfunction

  function automatic logic [8:0] act_w();
    return {bus.RegWriteW, bus.ResultSrcW, bus.RdW, bus.ValidW};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic flush, input logic zero, input logic [14:0] d);
    bus.FlushE = flush;
    bus.ZeroE  = zero;
    {bus.RegWriteD, bus.ResultSrcD, bus.MemWriteD, bus.JumpD, bus.BranchD,
     bus.ALUSrcD, bus.ALUControlD, bus.RdD} = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_E"}, 32'(act_e()), 32'd0);
    check({tag, "_M"}, 32'(act_m()), 32'd0);
    check({tag, "_W"}, 32'(act_w()), 32'd0);
    check({tag, "_PCSrcE"}, 32'(bus.PCSrcE), 32'd0);
  endtask

  initial begin
    // lw x5; sw flushed; beq taken; jal x1; add x2 flushed while jal redirects;
    // add x3; two nops; sw (unflushed); nop.
    vecs[0] = '{flush:1'b0, zero:1'b0, d:dv(1,2'b01,0,0,0,1,3'b000,5'd5),
                e:ev(1,1,2'b01,0,0,0,1,3'b000,5'd5), m:mv(0,0,2'b00,0,5'd0),
                w:wv(0,0,2'b00,5'd0), pc:1'b0};
    vecs[1] = '{flush:1'b1, zero:1'b0, d:dv(0,2'b00,1,0,0,1,3'b000,5'd7),
                e:16'd0, m:mv(1,1,2'b01,0,5'd5),
                w:wv(0,0,2'b00,5'd0), pc:1'b0};
    vecs[2] = '{flush:1'b0, zero:1'b1, d:dv(0,2'b00,0,0,1,0,3'b001,5'd0),
                e:ev(1,0,2'b00,0,0,1,0,3'b001,5'd0), m:mv(0,0,2'b00,0,5'd0),
                w:wv(1,1,2'b01,5'd5), pc:1'b1};
    vecs[3] = '{flush:1'b0, zero:1'b0, d:dv(1,2'b10,0,1,0,0,3'b000,5'd1),
                e:ev(1,1,2'b10,0,1,0,0,3'b000,5'd1), m:mv(1,0,2'b00,0,5'd0),
                w:wv(0,0,2'b00,5'd0), pc:1'b1};
    vecs[4] = '{flush:1'b1, zero:1'b1, d:dv(1,2'b00,0,0,0,0,3'b000,5'd2),
                e:16'd0, m:mv(1,1,2'b10,0,5'd1),
                w:wv(1,0,2'b00,5'd0), pc:1'b0};
    vecs[5] = '{flush:1'b0, zero:1'b0, d:dv(1,2'b00,0,0,0,0,3'b000,5'd3),
                e:ev(1,1,2'b00,0,0,0,0,3'b000,5'd3), m:mv(0,0,2'b00,0,5'd0),
                w:wv(1,1,2'b10,5'd1), pc:1'b0};
    vecs[6] = '{flush:1'b0, zero:1'b0, d:15'd0,
                e:ev(1,0,2'b00,0,0,0,0,3'b000,5'd0), m:mv(1,1,2'b00,0,5'd3),
                w:wv(0,0,2'b00,5'd0), pc:1'b0};
    vecs[7] = '{flush:1'b0, zero:1'b0, d:15'd0,
                e:ev(1,0,2'b00,0,0,0,0,3'b000,5'd0), m:mv(1,0,2'b00,0,5'd0),
                w:wv(1,1,2'b00,5'd3), pc:1'b0};
    vecs[8] = '{flush:1'b0, zero:1'b0, d:dv(0,2'b00,1,0,0,1,3'b000,5'd7),
                e:ev(1,0,2'b00,1,0,0,1,3'b000,5'd7), m:mv(1,0,2'b00,0,5'd0),
                w:wv(1,0,2'b00,5'd0), pc:1'b0};
    vecs[9] = '{flush:1'b0, zero:1'b0, d:15'd0,
                e:ev(1,0,2'b00,0,0,0,0,3'b000,5'd0), m:mv(1,0,2'b00,1,5'd7),
                w:wv(1,0,2'b00,5'd0), pc:1'b0};

    // Reset for two cycles with random decode inputs.
    reset = 1'b1;
    drive(1'b0, 1'b0, 15'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b0, 1'($urandom_range(1)), 15'($urandom));
      @(posedge clk);
      #1;
      check_all_zero($sformatf("reset_c%0d", c));
    end

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].flush, vecs[i].zero, vecs[i].d);
      @(posedge clk);
      #1;
      check($sformatf("row%0d_E", i), 32'(act_e()), 32'(vecs[i].e));
      check($sformatf("row%0d_M", i), 32'(act_m()), 32'(vecs[i].m));
      check($sformatf("row%0d_W", i), 32'(act_w()), 32'(vecs[i].w));
      check($sformatf("row%0d_PCSrcE", i), 32'(bus.PCSrcE), 32'(vecs[i].pc));
      @(negedge clk);
    end

    // beq sitting in E: PCSrcE follows ZeroE combinationally.
    drive(1'b0, 1'b0, dv(0,2'b00,0,0,1,0,3'b001,5'd0));
    @(posedge clk);
    #1;
    check("beq_not_taken", 32'(bus.PCSrcE), 32'd0);
    bus.ZeroE = 1'b1;
    #1;
    check("beq_taken", 32'(bus.PCSrcE), 32'd1);

    // Mid-stream reset discards all three stages in one edge.
    @(negedge clk);
    drive(1'b0, 1'b1, dv(1,2'b10,0,1,0,0,3'b000,5'd9));
    @(posedge clk);
    #1;
    check("prereset_validE", 32'(bus.ValidE), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 15'd0);

`ifdef CTRL_BUBBLE_CNT_EN
    // Four flush cycles, then reset, then wrap from all-ones.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.FlushE = 1'b1;
    repeat (4) @(negedge clk);
    bus.FlushE = 1'b0;
    check("bubble_cnt_4", bubble_cnt, 32'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("bubble_cnt_reset", bubble_cnt, 32'd0);
    force dut.BubbleCnt = 32'hFFFF_FFFF;
    #1;
    release dut.BubbleCnt;
    bus.FlushE = 1'b1;
    @(negedge clk);
    bus.FlushE = 1'b0;
    check("bubble_cnt_wrap", bubble_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_regs.md
Name: ctrl_pipe_regs

Overview:
- Carries main-decoder and ALU-decoder control outputs from Decode through the ID/EX, EX/MEM and MEM/WB pipeline boundaries of the pipelined RV32I core.
- Generates the Execute-stage branch/jump redirect PCSrcE.
- Sits directly downstream of the main decoder and ALU decoder. Feeds the datapath muxes, data memory write enable, register-file write port and hazard unit.

Parameters:
- RD_W, 5, destination register index width
- ALUCTRL_W, 3, ALUControl width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- FlushE  in  1  replace the instruction entering Execute with a bubble (from hazard unit)
- RegWriteD  in  1  decoder RegWrite
- ResultSrcD  in  2  decoder ResultSrc (00 ALU, 01 mem, 10 PC+4)
- MemWriteD  in  1  decoder MemWrite
- JumpD  in  1  decoder Jump
- BranchD  in  1  decoder Branch
- ALUSrcD  in  1  decoder ALUSrc
- ALUControlD  in  ALUCTRL_W  ALU decoder output
- RdD  in  RD_W  destination register
- ZeroE  in  1  ALU zero flag, Execute stage
- RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE, RdE  out  as D  Execute-stage copies
- ValidE  out  1  Execute slot holds a real instruction
- PCSrcE  out  1  redirect fetch (combinational)
- RegWriteM, ResultSrcM, MemWriteM, RdM, ValidM  out  1/2/1/RD_W/1  Memory-stage copies
- RegWriteW, ResultSrcW, RdW, ValidW  out  1/2/RD_W/1  Writeback-stage copies

Behaviour:
- Three register banks: E, M and W. All banks update on every rising clk edge. There is no stall input; Execute and later stages never stall.
- Reset (highest priority):
  - All registered outputs clear to 0 on the edge where reset=1, including ValidE/M/W=0.
  - A reset asserted mid-stream discards all three stages in one edge.
- E bank:
  - If FlushE=1, load a bubble: all E fields 0, ValidE=0.
  - Otherwise, load the D inputs with ValidE=1.
  - FlushE overrides any D value, including JumpD=1 or MemWriteD=1.
- M bank: loads RegWriteE, ResultSrcE, MemWriteE, RdE and ValidE unconditionally. A bubble in E becomes a bubble in M one cycle later.
- W bank: loads RegWriteM, ResultSrcM, RdM and ValidM unconditionally.
- Latency: a D value appears at the E outputs 1 cycle later, at M after 2 cycles, and at W after 3 cycles.
- PCSrcE = (BranchE & ZeroE) | JumpE. It is purely combinational from registered E state and ZeroE, and is 0 during reset and for bubbles.
- Bubble invariant: a bubble never writes the register file or memory. RegWrite and MemWrite are 0 at every stage whenever the matching Valid bit is 0.
- Simultaneous events:
  - FlushE=1 in the same cycle that PCSrcE=1 flushes only the incoming instruction.
  - The instruction already in E still advances to M with its own controls; a jump in E still reaches W with RegWrite=1 and ResultSrc=10.
- RdE/RdM/RdW of a bubble are 0. The hazard unit's forwarding compare therefore never matches a bubble except on x0, which the hazard unit already ignores.

Optional Feature:
- Macro CTRL_BUBBLE_CNT_EN.
- When defined:
  - Adds output BubbleCnt, 32 bits.
  - BubbleCnt increments on each edge where FlushE=1 and reset=0, and wraps from 0xFFFFFFFF to 0.
  - reset clears it to 0.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- reset=1 for 2 cycles with random D inputs -> every registered output is 0, ValidE/M/W=0, PCSrcE=0.
- lw decode (RegWriteD=1, ResultSrcD=01, ALUSrcD=1, RdD=5) at cycle 0 ->
  - cycle 1: E fields match, ValidE=1.
  - cycle 2: RegWriteM=1, ResultSrcM=01, RdM=5.
  - cycle 3: RegWriteW=1, ResultSrcW=01, RdW=5, ValidW=1.
- sw decode (MemWriteD=1, RdD=7) with FlushE=1 -> next cycle all E fields 0, ValidE=0. Following cycle MemWriteM=0, ValidM=0.
- beq in E (BranchE=1): ZeroE=1 -> PCSrcE=1; ZeroE=0 -> PCSrcE=0. jal in E (JumpE=1, ZeroE=0) -> PCSrcE=1; two cycles later ResultSrcW=10, RegWriteW=1.
- Back-to-back stream of add x1 / add x2 / add x3 with FlushE pulsed on the 2nd instruction -> RdW sequence 1, 0, 3 with ValidW 1, 0, 1.
- With CTRL_BUBBLE_CNT_EN defined: FlushE high for 4 cycles, then reset asserted -> BubbleCnt reads 4, then 0. Preload via force to 0xFFFFFFFF plus one flush -> BubbleCnt=0.
